// File: rtl/midori_pkg.sv
// Shared constants, state type and helpers for the Midori
// MixColumn arbiter slice.
package midori_pkg;
  localparam int STATE_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int COL_BYTES = 4;
  localparam int N_BYTES   = STATE_W / BYTE_W;
  localparam int N_COLS    = N_BYTES / COL_BYTES;

  typedef logic [N_BYTES-1:0][BYTE_W-1:0] state_t;

  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/midori_mix_column.sv
// Midori almost-MDS MixColumn: each output byte is the XOR
// of the other three bytes of its column.
module midori_mix_column
  import midori_pkg::*;
(
  input  state_t st_i,
  output state_t st_o
);
  logic [BYTE_W-1:0] col_x;

  always_comb begin
    st_o  = '0;
    col_x = '0;
    for (int c = 0; c < N_COLS; c++) begin
      col_x = st_i[COL_BYTES*c]   ^ st_i[COL_BYTES*c+1] ^
              st_i[COL_BYTES*c+2] ^ st_i[COL_BYTES*c+3];
      // Folding the own byte back in cancels it out
      for (int k = 0; k < COL_BYTES; k++)
        st_o[COL_BYTES*c+k] = col_x ^ st_i[COL_BYTES*c+k];
    end
  end
endmodule

// File: rtl/midori_rr_arb.sv
// Combinational round-robin arbiter: first valid request
// scanning from ptr_i upward, modulo N_REQ.
module midori_rr_arb
  import midori_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SW    = src_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [SW-1:0]    ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [SW-1:0]    win_o,
  output logic             any_o
);
  localparam int IW = SW + 1;

  logic [IW-1:0] idx;

  always_comb begin
    grant_o = '0;
    win_o   = '0;
    any_o   = 1'b0;
    idx     = '0;
    // Walk from the farthest offset back so the closest wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + IW'(k);
      if (idx >= IW'(N_REQ))
        idx = idx - IW'(N_REQ);
      if (en_i && req_i[idx[SW-1:0]]) begin
        win_o = idx[SW-1:0];
        any_o = 1'b1;
      end
    end
    if (any_o)
      grant_o[win_o] = 1'b1;
  end
endmodule

// File: rtl/midori_mc_arbiter.sv
// Round-robin time-sharing of one MixColumn datapath among
// N_REQ requesters, with a registered tagged response.
module midori_mc_arbiter
  import midori_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SRC_W = src_w(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*STATE_W-1:0] req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [STATE_W-1:0]       rsp_data,
  output logic [SRC_W-1:0]         rsp_src,
  input  logic                     rsp_ready
);
  logic             out_free;
  logic             arb_en;
  logic             any_grant;
  logic [SRC_W-1:0] winner;
  state_t           win_state;
  state_t           mc_state;

  logic             rsp_valid_q, rsp_valid_d;
  state_t           rsp_data_q, rsp_data_d;
  logic [SRC_W-1:0] rsp_src_q, rsp_src_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  assign out_free = !rsp_valid_q || rsp_ready;
  assign arb_en   = out_free && rst_n;

  midori_rr_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (arb_en),
    .grant_o (req_ready),
    .win_o   (winner),
    .any_o   (any_grant)
  );

  always_comb begin
    win_state = '0;
    for (int i = 0; i < N_REQ; i++)
      if (winner == SRC_W'(i))
        win_state = req_data[i*STATE_W +: STATE_W];
  end

  midori_mix_column u_mc (
    .st_i (win_state),
    .st_o (mc_state)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_src_d   = rsp_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (any_grant) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mc_state;
      rsp_src_d   = winner;
      rr_ptr_d    = (winner == SRC_W'(N_REQ - 1))
                    ? '0 : winner + 1'b1;
    end else if (out_free) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_src_q   <= rsp_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_src   = rsp_src_q;
endmodule

// File: tb/tb_midori_mc_arbiter.sv
// Self-checking bench for midori_mc_arbiter (N_REQ=4 and 3)
// against a queue-free behavioural reference model.
module tb_midori_mc_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]     req_valid, req_ready;
  logic [N*128-1:0] req_data;
  logic             rsp_valid, rsp_ready;
  logic [127:0]     rsp_data;
  logic [1:0]       rsp_src;

  logic [2:0]       v3, r3;
  logic [3*128-1:0] d3;
  logic             rv3, rr3;
  logic [127:0]     rd3;
  logic [1:0]       rs3;

  int checks = 0;
  int errors = 0;

  logic         m_valid;
  logic [127:0] m_data;
  int           m_src, m_ptr, last_w;

  always #5 clk = ~clk;

  midori_mc_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_ready(rsp_ready)
  );

  midori_mc_arbiter #(.N_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_data(d3),
    .req_ready(r3),
    .rsp_valid(rv3), .rsp_data(rd3),
    .rsp_src(rs3), .rsp_ready(rr3)
  );

  function automatic logic [127:0] mc_ref(input logic [127:0] s);
    logic [127:0] r = '0;
    logic [7:0]   b;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++)
          if (j != k) b ^= s[8*(4*c+j) +: 8];
        r[8*(4*c+k) +: 8] = b;
      end
    return r;
  endfunction

  function automatic int m_pick();
    if (!rst_n || (m_valid && !rsp_ready)) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    int w = m_pick();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  task automatic tick();
    int w;
    w = m_pick();
    @(posedge clk);
    last_w = w;
    if (!rst_n) model_reset();
    else if (w >= 0) begin
      m_valid = 1'b1;
      m_data  = mc_ref(req_data[128*w +: 128]);
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else if (!m_valid || rsp_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [127:0] d0;
    rst_n = 1'b0;
    model_reset();
    req_valid = '1;
    for (int i = 0; i < N * 4; i++)
      req_data[32*i +: 32] = $urandom;
    d0 = req_data[127:0];
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_src !== 2'd0) begin
      errors++;
      $display("FAIL rst_rsp got v=%b s=%0d d=%h exp 0",
               rsp_valid, rsp_src, rsp_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rel_ready got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd0 ||
        rsp_data !== mc_ref(d0)) begin
      errors++;
      $display("FAIL rel_rsp got v=%b s=%0d d=%h exp v=1 s=0 d=%h",
               rsp_valid, rsp_src, rsp_data, mc_ref(d0));
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[2*128 +: 128] = 128'h1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd2 ||
        rsp_data !== 128'h0101_0100) begin
      errors++;
      $display("FAIL single_rsp got v=%b s=%0d d=%h exp v=1 s=2 d=01010100",
               rsp_valid, rsp_src, rsp_data);
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    req_valid = '1;
    req_data  = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      #1;
      checks++;
      if (req_ready !== exp) begin
        errors++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_src !== 2'(i % 4) ||
          rsp_data !== {128{1'b1}}) begin
        errors++;
        $display("FAIL rr_rsp[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d d=all-ff",
                 i, rsp_valid, rsp_src, rsp_data, i % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] hd;
    logic [1:0]   hs;
    hd = rsp_data;
    hs = rsp_src;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_src !== hs) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                 i, rsp_valid, rsp_src, rsp_data, hs, hd);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release got=%b exp=0010", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd1) begin
      errors++;
      $display("FAIL bp_next got v=%b s=%0d exp v=1 s=1", rsp_valid, rsp_src);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst got v=%b rdy=%b exp v=0 rdy=0000",
               rsp_valid, req_ready);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (rsp_src !== 2'd0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rsp got v=%b s=%0d exp v=1 s=0", rsp_valid, rsp_src);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          for (int w = 0; w < 4; w++)
            req_data[128*i + 32*w +: 32] = $urandom;
        end
      rsp_ready = ($urandom % 4) != 0;
      #1;
      er = m_ready();
      checks++;
      if (req_ready !== er) begin
        errors++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b", cyc, req_ready, er);
      end
      tick();
      checks++;
      if (rsp_valid !== m_valid || rsp_src !== 2'(m_src) ||
          rsp_data !== m_data) begin
        errors++;
        $display("FAIL rnd_rsp c=%0d got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
                 cyc, rsp_valid, rsp_src, rsp_data, m_valid, m_src, m_data);
      end
      if (last_w >= 0) req_valid[last_w] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_n3_wrap();
    logic [2:0] eg;
    int         es;
    rst_n = 1'b0;
    model_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    rr3 = 1'b1;
    for (int i = 0; i < 12; i++) d3[32*i +: 32] = $urandom;
    v3 = 3'b010;
    #1;
    checks++;
    if (r3 !== 3'b010) begin
      errors++;
      $display("FAIL n3_first got=%b exp=010", r3);
    end
    tick();
    checks++;
    if (rv3 !== 1'b1 || rs3 !== 2'd1) begin
      errors++;
      $display("FAIL n3_first_rsp got v=%b s=%0d exp v=1 s=1", rv3, rs3);
    end
    v3 = 3'b110;
    for (int i = 0; i < 3; i++) begin
      es = (i == 1) ? 1 : 2;
      eg = 3'b001 << es;
      #1;
      checks++;
      if (r3 !== eg) begin
        errors++;
        $display("FAIL n3_ready[%0d] got=%b exp=%b", i, r3, eg);
      end
      tick();
      checks++;
      if (rv3 !== 1'b1 || rs3 !== 2'(es) ||
          rd3 !== mc_ref(d3[128*es +: 128])) begin
        errors++;
        $display("FAIL n3_rsp[%0d] got v=%b s=%0d d=%h exp s=%0d d=%h",
                 i, rv3, rs3, rd3, es, mc_ref(d3[128*es +: 128]));
      end
    end
    v3 = '0;
  endtask

  initial begin
    v3 = '0;
    d3 = '0;
    rr3 = 1'b1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b1;
    last_w = -1;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_n3_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
